data_ram_responder: RTL and testbench
=====================================

# data_ram_responder

Memory-side responder for the pipeline's M-stage data port. It accepts a byte-address, lane-aligned write data and 4-bit read/write lane enables from the datapath, and services them from an internal word-organised RAM after a programmable number of wait states. It also drives a stall back to the hazard logic until the access completes. It sits between the core's M stage and the data SRAM, standing in for a bus bridge in simulation and FPGA builds.

## Interface
- ADDR_W, 10, word-address bits (RAM depth = 2^ADDR_W words)
- WAIT_CYCLES, 2, extra wait states per access, legal 0..15
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- addr  in  32  byte address (M-stage ALU result); addr[1:0] ignored
- rd_en  in  4  read lane enables; any bit set = read request
- wr_en  in  4  write byte-lane enables; bit i writes wdata[8i+7:8i]
- wdata  in  32  write data, already lane-aligned by the core
- rdata  out  32  full word read, registered
- stall  out  1  combinational; high while a request is pending and not yet done
- ack  out  1  registered; one-cycle completion pulse
- addr_err  out  1  registered; pulses with ack when the address is out of range

## Operation
- Request present (req) = |rd_en | |wr_en. The core holds addr, rd_en, wr_en and wdata stable while stall=1.
- States:
  - IDLE: on req, load cnt=WAIT_CYCLES. Go to DONE if WAIT_CYCLES=0, else go to WAIT.
  - WAIT: decrement cnt. Go to DONE when cnt reaches 1.
  - DONE: ack=1. Return to IDLE unconditionally.
- stall = req & (state != DONE).
- In range means addr[31:ADDR_W+2] == 0. Word index = addr[ADDR_W+1:2].
- Read, in range: rdata is loaded with mem[index] on the edge entering DONE and held until the next DONE entry.
- Write, in range: lanes with wr_en set are written on the edge leaving DONE. rdata is unchanged.
- rd_en and wr_en both nonzero: the write is performed, and rdata returns the pre-write word.
- Out of range: no write, rdata loaded with 0, addr_err=1 together with ack.
- Request withdrawn (req=0) in WAIT, e.g. a pipeline flush: return to IDLE at the next edge with no write and no ack. A withdrawn request is never completed.
- Back-to-back: a request present in the cycle after DONE (state IDLE) starts a new access.

## Timing
- Reset values: state=IDLE, cnt=0, rdata=0, ack=0, addr_err=0. stall follows req, which is combinational.
- RAM contents are not reset.
- Reset asserted mid-access aborts the access: the write is dropped and the FSM goes to IDLE immediately.
- Latency: request first seen at cycle 0 reaches DONE at cycle WAIT_CYCLES+1.
- stall is high for WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, stall is high for exactly one cycle.
- rdata is valid from DONE onward, so the core's M→W register captures it in the DONE cycle (stall=0).
- No request in IDLE: stall=0 and nothing changes.

## Structure
- The shared package holds:
  - the state enum (IDLE, WAIT, DONE), 2-bit encoding
  - the WAIT_CYCLES width constant (4)
  - the lane-count constant (4)
- Sub-module bram_be: single-port 2^ADDR_W×32 RAM with per-byte write enables and synchronous read. The responder owns the FSM, counter, range check and output registers.

## Test plan
- WAIT_CYCLES=2, write wr_en=4'b1111, addr=0x10, wdata=0xDEADBEEF; then read rd_en=4'b1111 at 0x10:
  - each access has stall high for 3 cycles, then a single ack pulse
  - the read returns rdata=0xDEADBEEF
- Byte write wr_en=4'b0100, wdata=0x00AA0000 to 0x10 over 0xDEADBEEF; read back → rdata=0xDEAABEEF.
- Address 0x0000_1000 with ADDR_W=10 (out of range):
  - read → addr_err=1 with ack, rdata=0
  - write → RAM unchanged (verified by reading back index 0)
- Request dropped during WAIT (rd_en→0 in the second stall cycle) → FSM back to IDLE, no ack. A following write to the same address completes normally.
- rst pulsed in WAIT of a write to 0x20 → rdata=0, ack=0, state IDLE. A later read of 0x20 returns the old contents.
- WAIT_CYCLES=0, two back-to-back reads → each has stall for 1 cycle, acks two cycles apart, and the rdata values match the RAM.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// Shared types and constants for the M-stage data RAM responder.
// Holds the FSM state encoding, the wait-state counter width and the lane count.
package data_ram_responder_pkg;
    localparam int CNT_W = 4;
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/data_ram_responder_if.sv
// M-stage data port bundle between the core (master) and the responder (slave).
interface data_ram_responder_if;
    import data_ram_responder_pkg::*;

    logic [31:0]      addr;
    logic [LANES-1:0] rd_en;
    logic [LANES-1:0] wr_en;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             stall;
    logic             ack;
    logic             addr_err;

    modport master (
        output addr, rd_en, wr_en, wdata,
        input  rdata, stall, ack, addr_err
    );

    modport slave (
        input  addr, rd_en, wr_en, wdata,
        output rdata, stall, ack, addr_err
    );
endinterface

// File: rtl/data_ram_responder_bram_be.sv
// Single-port word RAM with per-byte write enables and a synchronous read port.
// The read register holds its value whenever re is low.
module bram_be
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);
    logic [31:0] mem [2**ADDR_W];

    // Byte-lane write and read-before-write synchronous read port
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            q <= mem[addr];
        end
    end
endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder for the M-stage data port: inserts WAIT_CYCLES wait
// states, stalls the core meanwhile, and services the access from bram_be.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_ram_responder_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            state_r;
    state_t            next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              ack_r;
    logic              addr_err_r;
    logic              rdata_ok_r;

    logic              req_s;
    logic              rd_req_s;
    logic              in_range_s;
    logic              enter_done_s;
    logic              ram_re_s;
    logic [LANES-1:0]  ram_we_s;
    logic [ADDR_W-1:0] index_s;
    logic [31:0]       ram_q_s;
    logic              unused_s;

    assign rd_req_s   = |bus.rd_en;
    assign req_s      = rd_req_s | (|bus.wr_en);
    assign in_range_s = (bus.addr[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
    assign index_s    = bus.addr[ADDR_W+1:2];
    assign unused_s   = ^bus.addr[1:0];

    // Next-state and wait-state counter logic
    always_comb begin
        next_s     = state_r;
        cnt_next_s = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    cnt_next_s = CNT_LOAD;
                    next_s     = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end else begin
                    next_s = IDLE;
                end
            end
            WAIT: begin
                if (!req_s) begin
                    cnt_next_s = {CNT_W{1'b0}};
                    next_s     = IDLE;
                end else begin
                    cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    next_s     = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) ? DONE : WAIT;
                end
            end
            DONE: begin
                next_s = IDLE;
            end
            default: begin
                cnt_next_s = {CNT_W{1'b0}};
                next_s     = IDLE;
            end
        endcase
    end

    // The read is launched on the edge into DONE so rdata is valid in DONE;
    // the write lands on the edge leaving DONE, giving read-before-write.
    assign enter_done_s = (next_s == DONE);
    assign ram_re_s     = enter_done_s & rd_req_s & in_range_s;
    assign ram_we_s     = (state_r == DONE && in_range_s && !rst) ? bus.wr_en : {LANES{1'b0}};

    // FSM state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Completion pulse, range error and read-data qualifier registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r      <= 1'b0;
            addr_err_r <= 1'b0;
            rdata_ok_r <= 1'b0;
        end else begin
            ack_r      <= enter_done_s;
            addr_err_r <= enter_done_s & ~in_range_s;
            if (enter_done_s && !in_range_s) begin
                rdata_ok_r <= 1'b0;
            end else if (enter_done_s && rd_req_s) begin
                rdata_ok_r <= 1'b1;
            end
        end
    end

    bram_be #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (index_s),
        .wdata (bus.wdata),
        .q     (ram_q_s)
    );

    // RAM output register is forced to zero after reset or an out-of-range access
    assign bus.rdata    = rdata_ok_r ? ram_q_s : 32'h0000_0000;
    assign bus.ack      = ack_r;
    assign bus.addr_err = addr_err_r;
    assign bus.stall    = req_s & (state_r != DONE);
endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized self-checking bench: two responders (WAIT_CYCLES=2 and 0) checked
// against a word-array memory model and an expected-rdata register per instance.
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mem_m [2][1024];
    logic [31:0] rdata_m [2];
    logic [31:0] pool [8];

    data_ram_responder_if bus0 ();
    data_ram_responder_if bus1 ();

    data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic stall_of(input int sel);
        return (sel == 0) ? bus0.stall : bus1.stall;
    endfunction
    function automatic logic ack_of(input int sel);
        return (sel == 0) ? bus0.ack : bus1.ack;
    endfunction
    function automatic logic err_of(input int sel);
        return (sel == 0) ? bus0.addr_err : bus1.addr_err;
    endfunction
    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 0) ? bus0.rdata : bus1.rdata;
    endfunction

    task automatic drive(input int sel, input logic [31:0] a, input logic [3:0] rd,
                         input logic [3:0] wr, input logic [31:0] wd);
        bus0.addr = 32'h0; bus0.rd_en = 4'h0; bus0.wr_en = 4'h0; bus0.wdata = 32'h0;
        bus1.addr = 32'h0; bus1.rd_en = 4'h0; bus1.wr_en = 4'h0; bus1.wdata = 32'h0;
        if (sel == 0) begin
            bus0.addr = a; bus0.rd_en = rd; bus0.wr_en = wr; bus0.wdata = wd;
        end else begin
            bus1.addr = a; bus1.rd_en = rd; bus1.wr_en = wr; bus1.wdata = wd;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
        #1;
        check_eq("idle_ack0", {31'd0, bus0.ack}, 32'd0);
        check_eq("idle_ack1", {31'd0, bus1.ack}, 32'd0);
        check_eq("idle_stall0", {31'd0, bus0.stall}, 32'd0);
    endtask

    // Full access: stall for wait+1 cycles, then one DONE cycle with ack.
    task automatic do_access(input int sel, input logic [31:0] a, input logic [3:0] rd,
                             input logic [3:0] wr, input logic [31:0] wd);
        int          w;
        logic        oor;
        logic [9:0]  idx;
        w   = (sel == 0) ? 2 : 0;
        oor = (a[31:12] != 20'h0);
        idx = a[11:2];
        @(negedge clk);
        drive(sel, a, rd, wr, wd);
        for (int k = 0; k <= w; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check_eq("busy_stall", {31'd0, stall_of(sel)}, 32'd1);
            check_eq("busy_ack", {31'd0, ack_of(sel)}, 32'd0);
        end
        @(negedge clk);
        #1;
        if (oor) rdata_m[sel] = 32'h0;
        else if (rd != 4'h0) rdata_m[sel] = mem_m[sel][idx];
        check_eq("done_stall", {31'd0, stall_of(sel)}, 32'd0);
        check_eq("done_ack", {31'd0, ack_of(sel)}, 32'd1);
        check_eq("done_err", {31'd0, err_of(sel)}, {31'd0, oor});
        check_eq("done_rdata", rdata_of(sel), rdata_m[sel]);
        if (!oor) begin
            for (int i = 0; i < 4; i++) begin
                if (wr[i]) mem_m[sel][idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  rd;
        logic [3:0]  wr;
        int          sel;
        checks = 0;
        errors = 0;
        rdata_m[0] = 32'h0;
        rdata_m[1] = 32'h0;
        pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0010; pool[2] = 32'h0000_0020;
        pool[3] = 32'h0000_0004; pool[4] = 32'h0000_0008; pool[5] = 32'h0000_000C;
        pool[6] = 32'h0000_0190; pool[7] = 32'h0000_0FFC;
        rst = 1'b1;
        drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
        #12;
        check_eq("rst_rdata0", bus0.rdata, 32'h0);
        check_eq("rst_rdata1", bus1.rdata, 32'h0);
        check_eq("rst_ack0", {31'd0, bus0.ack}, 32'd0);
        check_eq("rst_err0", {31'd0, bus0.addr_err}, 32'd0);
        check_eq("rst_stall0", {31'd0, bus0.stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 8; p++) begin
                do_access(s, pool[p], 4'h0, 4'hF, $urandom);
                idle();
            end
        end

        // Full-word write then read of 0x10
        do_access(0, 32'h0000_0010, 4'h0, 4'hF, 32'hDEAD_BEEF);
        idle();
        do_access(0, 32'h0000_0010, 4'hF, 4'h0, 32'h0);
        check_eq("rd_deadbeef", bus0.rdata, 32'hDEAD_BEEF);
        idle();
        // Byte lane 2 write
        do_access(0, 32'h0000_0010, 4'h0, 4'b0100, 32'h00AA_0000);
        idle();
        do_access(0, 32'h0000_0010, 4'hF, 4'h0, 32'h0);
        check_eq("rd_deaabeef", bus0.rdata, 32'hDEAA_BEEF);
        idle();
        // Out of range read and write
        do_access(0, 32'h0000_1000, 4'hF, 4'h0, 32'h0);
        idle();
        do_access(0, 32'h0000_1000, 4'h0, 4'hF, 32'h1234_5678);
        idle();
        do_access(0, 32'h0000_0000, 4'hF, 4'h0, 32'h0);
        idle();

        // Read withdrawn in the second stall cycle
        @(negedge clk);
        drive(0, 32'h0000_0010, 4'hF, 4'h0, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
        #1;
        check_eq("drop_stall", {31'd0, bus0.stall}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_eq("drop_noack", {31'd0, bus0.ack}, 32'd0);
        end
        check_eq("drop_idle", {30'd0, dut0.state_r}, {30'd0, IDLE});
        do_access(0, 32'h0000_0010, 4'h0, 4'hF, 32'hCAFE_F00D);
        idle();
        do_access(0, 32'h0000_0010, 4'hF, 4'h0, 32'h0);
        idle();

        // Reset pulsed during WAIT of a write to 0x20
        @(negedge clk);
        drive(0, 32'h0000_0020, 4'h0, 4'hF, 32'h0BAD_0BAD);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        rdata_m[0] = 32'h0;
        rdata_m[1] = 32'h0;
        check_eq("rstw_rdata", bus0.rdata, 32'h0);
        check_eq("rstw_ack", {31'd0, bus0.ack}, 32'd0);
        check_eq("rstw_idle", {30'd0, dut0.state_r}, {30'd0, IDLE});
        @(negedge clk);
        drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
        rst = 1'b0;
        do_access(0, 32'h0000_0020, 4'hF, 4'h0, 32'h0);
        idle();

        // Zero-wait instance: back-to-back reads
        do_access(1, 32'h0000_0010, 4'hF, 4'h0, 32'h0);
        do_access(1, 32'h0000_0190, 4'h1, 4'h0, 32'h0);
        idle();

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 1);
            a   = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a | (32'h0000_1000 << $urandom_range(0, 19));
            rd = 4'($urandom_range(0, 15));
            wr = 4'($urandom_range(0, 15));
            if (rd == 4'h0 && wr == 4'h0) rd = 4'b0001;
            do_access(sel, a, rd, wr, $urandom);
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
